// File: rtl/amber48_dmem_arb_if.sv
// -----------------------------------------------------------------------------
// amber48_dmem_arb_if
// Bus bundle between the two data-memory requesters (m0 = core, m1 = debug /
// loader), the arbiter and the amber48_dmem slave.
//   m0_*/m1_* : requester side (req, we, addr, wdata in; rdata, ready, trap out)
//   s_*       : memory side (req, we, addr, wdata out; rdata, ready, trap in)
// Modports:
//   slave  : the arbiter's view (receives requester traffic, drives memory)
//   master : the environment's view (drives requests, models the memory)
// -----------------------------------------------------------------------------
interface amber48_dmem_arb_if #(
  parameter int XLEN = 48
);
  logic            m0_req_i;
  logic            m0_we_i;
  logic [XLEN-1:0] m0_addr_i;
  logic [XLEN-1:0] m0_wdata_i;
  logic [XLEN-1:0] m0_rdata_o;
  logic            m0_ready_o;
  logic            m0_trap_o;

  logic            m1_req_i;
  logic            m1_we_i;
  logic [XLEN-1:0] m1_addr_i;
  logic [XLEN-1:0] m1_wdata_i;
  logic [XLEN-1:0] m1_rdata_o;
  logic            m1_ready_o;
  logic            m1_trap_o;

  logic            s_req_o;
  logic            s_we_o;
  logic [XLEN-1:0] s_addr_o;
  logic [XLEN-1:0] s_wdata_o;
  logic [XLEN-1:0] s_rdata_i;
  logic            s_ready_i;
  logic            s_trap_i;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m0_rdata_o, m0_ready_o, m0_trap_o,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output m1_rdata_o, m1_ready_o, m1_trap_o,
    output s_req_o, s_we_o, s_addr_o, s_wdata_o,
    input  s_rdata_i, s_ready_i, s_trap_i
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m0_rdata_o, m0_ready_o, m0_trap_o,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  m1_rdata_o, m1_ready_o, m1_trap_o,
    input  s_req_o, s_we_o, s_addr_o, s_wdata_o,
    output s_rdata_i, s_ready_i, s_trap_i
  );
endinterface

// File: rtl/amber48_dmem_arb.sv
// -----------------------------------------------------------------------------
// amber48_dmem_arb
// Two-port arbiter in front of amber48_dmem. One access is in flight at a time:
// in IDLE a winner is picked and its request fields are latched; in BUSY the
// latched access is presented to the memory until s_ready_i or a timeout, and
// the completion (ready/rdata/trap) is routed back to the granted port only.
//
// Ports:
//   clk_i, rst_ni : clock (rising edge) and asynchronous active-low reset
//   bus (slave)   : m0/m1 requester ports and s_* memory port
//   busy_o        : an access is in flight (FSM in BUSY)
//   grant_o       : index of the port granted most recently (held)
//
// Parameters:
//   TIMEOUT_CYCLES : BUSY cycles allowed before a trap completion, 0 = never
//
// Build option:
//   AMBER48_DMEM_ARB_RR_EN : round-robin arbitration instead of m0-first
// -----------------------------------------------------------------------------
package amber48_pkg;
  localparam int XLEN = 48;
endpackage

module amber48_dmem_arb
  import amber48_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  amber48_dmem_arb_if.slave bus,
  output logic              busy_o,
  output logic              grant_o
);

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              we_r;
  logic [XLEN-1:0]   addr_r;
  logic [XLEN-1:0]   wdata_r;
  logic              grant_r;

  logic              any_req_s;
  logic              win_s;
  logic              timeout_s;
  logic              done_s;
  logic              cpl_trap_s;
  logic [XLEN-1:0]   cpl_rdata_s;

  logic              s_req_s;
  logic              s_we_s;
  logic [XLEN-1:0]   s_addr_s;
  logic [XLEN-1:0]   s_wdata_s;
  logic              m0_ready_s;
  logic              m0_trap_s;
  logic [XLEN-1:0]   m0_rdata_s;
  logic              m1_ready_s;
  logic              m1_trap_s;
  logic [XLEN-1:0]   m1_rdata_s;

`ifdef AMBER48_DMEM_ARB_RR_EN
  // Port favoured when both request; reset favours m0.
  logic              rr_next_r;
`endif

  assign any_req_s = bus.m0_req_i | bus.m1_req_i;

  // Winner selection among the current requesters.
  always_comb begin
    win_s = 1'b0;
    if (bus.m0_req_i && bus.m1_req_i) begin
`ifdef AMBER48_DMEM_ARB_RR_EN
      win_s = rr_next_r;
`else
      win_s = 1'b0;
`endif
    end else if (bus.m1_req_i) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Completion detection: memory ready wins over a coincident timeout.
  always_comb begin
    timeout_s   = 1'b0;
    done_s      = 1'b0;
    cpl_trap_s  = 1'b0;
    cpl_rdata_s = {XLEN{1'b0}};
    if (state_r == ST_BUSY) begin
      timeout_s = TO_EN && !bus.s_ready_i && (cnt_r == CNT_LAST);
      done_s    = bus.s_ready_i | timeout_s;
      if (bus.s_ready_i) begin
        cpl_trap_s  = bus.s_trap_i;
        cpl_rdata_s = bus.s_rdata_i;
      end else begin
        cpl_trap_s  = 1'b1;
        cpl_rdata_s = {XLEN{1'b0}};
      end
    end else begin
      timeout_s   = 1'b0;
      done_s      = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Latch the winner's access and grant index at the IDLE->BUSY hand-off.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_r    <= 1'b0;
      addr_r  <= {XLEN{1'b0}};
      wdata_r <= {XLEN{1'b0}};
      grant_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && any_req_s) begin
      we_r    <= win_s ? bus.m1_we_i    : bus.m0_we_i;
      addr_r  <= win_s ? bus.m1_addr_i  : bus.m0_addr_i;
      wdata_r <= win_s ? bus.m1_wdata_i : bus.m0_wdata_i;
      grant_r <= win_s;
    end
  end

`ifdef AMBER48_DMEM_ARB_RR_EN
  // Round-robin pointer: after each grant the other port is favoured.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_next_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && any_req_s) begin
      rr_next_r <= ~win_s;
    end
  end
`endif

  // Wait counter: held at zero in IDLE so it starts from zero in BUSY.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_IDLE) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!done_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Memory-side drive and completion routing to the granted port only.
  always_comb begin
    s_req_s    = 1'b0;
    s_we_s     = 1'b0;
    s_addr_s   = {XLEN{1'b0}};
    s_wdata_s  = {XLEN{1'b0}};
    m0_ready_s = 1'b0;
    m0_trap_s  = 1'b0;
    m0_rdata_s = {XLEN{1'b0}};
    m1_ready_s = 1'b0;
    m1_trap_s  = 1'b0;
    m1_rdata_s = {XLEN{1'b0}};
    if (state_r == ST_BUSY) begin
      s_req_s   = 1'b1;
      s_we_s    = we_r;
      s_addr_s  = addr_r;
      s_wdata_s = wdata_r;
      if (done_s && !grant_r) begin
        m0_ready_s = 1'b1;
        m0_trap_s  = cpl_trap_s;
        m0_rdata_s = cpl_rdata_s;
      end else if (done_s && grant_r) begin
        m1_ready_s = 1'b1;
        m1_trap_s  = cpl_trap_s;
        m1_rdata_s = cpl_rdata_s;
      end else begin
        m0_ready_s = 1'b0;
        m1_ready_s = 1'b0;
      end
    end else begin
      s_req_s = 1'b0;
    end
  end

  assign bus.s_req_o    = s_req_s;
  assign bus.s_we_o     = s_we_s;
  assign bus.s_addr_o   = s_addr_s;
  assign bus.s_wdata_o  = s_wdata_s;
  assign bus.m0_ready_o = m0_ready_s;
  assign bus.m0_trap_o  = m0_trap_s;
  assign bus.m0_rdata_o = m0_rdata_s;
  assign bus.m1_ready_o = m1_ready_s;
  assign bus.m1_trap_o  = m1_trap_s;
  assign bus.m1_rdata_o = m1_rdata_s;

  assign busy_o  = (state_r == ST_BUSY);
  assign grant_o = grant_r;

endmodule

// File: tb/tb_amber48_dmem_arb.sv
// -----------------------------------------------------------------------------
// tb_amber48_dmem_arb
// Directed stimulus against amber48_dmem_arb (TIMEOUT_CYCLES = 4). A transaction
// level model (in-flight flag, owner, captured access, age in BUSY cycles) gives
// every output each cycle; directed steps add literal expectations.
// -----------------------------------------------------------------------------
module tb_amber48_dmem_arb;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic grant;

  int n_cmp = 0;
  int n_err = 0;

  amber48_dmem_arb_if #(.XLEN(48)) bus ();

  amber48_dmem_arb #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus),
    .busy_o  (busy),
    .grant_o (grant)
  );

  always #5 clk = ~clk;

  logic any_out;
  assign any_out = |{bus.m0_rdata_o, bus.m0_ready_o, bus.m0_trap_o,
                     bus.m1_rdata_o, bus.m1_ready_o, bus.m1_trap_o,
                     bus.s_req_o, bus.s_we_o, bus.s_addr_o, bus.s_wdata_o,
                     busy, grant};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          m_busy  = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_we    = 1'b0;
  logic [47:0] m_addr  = 48'h0;
  logic [47:0] m_wdata = 48'h0;
  int          m_age   = 0;     // 1 in the first BUSY cycle
`ifdef AMBER48_DMEM_ARB_RR_EN
  bit          m_pref  = 1'b0;  // port favoured on contention
`endif

  function automatic bit m_done();
    return m_busy && (bus.s_ready_i || (TO != 0 && m_age == TO));
  endfunction

  function automatic bit m_pick();
    if (bus.m0_req_i && bus.m1_req_i) begin
`ifdef AMBER48_DMEM_ARB_RR_EN
      return m_pref;
`else
      return 1'b0;
`endif
    end
    return bus.m1_req_i;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_owner <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= 48'h0;
      m_wdata <= 48'h0;
      m_age   <= 0;
`ifdef AMBER48_DMEM_ARB_RR_EN
      m_pref  <= 1'b0;
`endif
    end else if (m_busy) begin
      if (m_done()) m_busy <= 1'b0;
      else          m_age  <= m_age + 1;
    end else if (bus.m0_req_i || bus.m1_req_i) begin
      m_busy  <= 1'b1;
      m_age   <= 1;
      m_owner <= m_pick();
      m_we    <= m_pick() ? bus.m1_we_i    : bus.m0_we_i;
      m_addr  <= m_pick() ? bus.m1_addr_i  : bus.m0_addr_i;
      m_wdata <= m_pick() ? bus.m1_wdata_i : bus.m0_wdata_i;
`ifdef AMBER48_DMEM_ARB_RR_EN
      m_pref  <= ~m_pick();
`endif
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    bit          live, d, r0, r1, tr;
    logic [47:0] rd;
    live = rst_n && m_busy;
    d    = rst_n && m_done();
    r0   = d && !m_owner;
    r1   = d && m_owner;
    tr   = bus.s_ready_i ? bus.s_trap_i : 1'b1;
    rd   = bus.s_ready_i ? bus.s_rdata_i : 48'h0;
    chk("cyc_busy",   busy,           live);
    chk("cyc_grant",  grant,          rst_n ? m_owner : 1'b0);
    chk("cyc_s_req",  bus.s_req_o,    live);
    chk("cyc_s_we",   bus.s_we_o,     live ? m_we : 1'b0);
    chk("cyc_s_addr", bus.s_addr_o,   live ? m_addr : 48'h0);
    chk("cyc_s_wdat", bus.s_wdata_o,  live ? m_wdata : 48'h0);
    chk("cyc_m0_rdy", bus.m0_ready_o, r0);
    chk("cyc_m0_trp", bus.m0_trap_o,  r0 ? tr : 1'b0);
    chk("cyc_m0_rd",  bus.m0_rdata_o, r0 ? rd : 48'h0);
    chk("cyc_m1_rdy", bus.m1_ready_o, r1);
    chk("cyc_m1_trp", bus.m1_trap_o,  r1 ? tr : 1'b0);
    chk("cyc_m1_rd",  bus.m1_rdata_o, r1 ? rd : 48'h0);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.m0_req_i = 1'b0; bus.m0_we_i = 1'b0; bus.m0_addr_i = 48'h0; bus.m0_wdata_i = 48'h0;
    bus.m1_req_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_addr_i = 48'h0; bus.m1_wdata_i = 48'h0;
    bus.s_rdata_i = 48'h0; bus.s_ready_i = 1'b0; bus.s_trap_i = 1'b0;
  endtask

  initial begin
    logic g [0:2];
    logic ge [0:2];
    int   k;
    idle_inputs();

    // Reset state
    neg();
    chk("rst_outputs_zero", any_out, 1'b0);
    neg();
    step();
    rst_n = 1'b1;
    neg();
    chk("post_rst_idle", busy, 1'b0);

    // Both ports contend three times back to back
    step();
    bus.m0_req_i = 1'b1; bus.m0_addr_i = 48'h100;
    bus.m1_req_i = 1'b1; bus.m1_addr_i = 48'h200;
    bus.s_ready_i = 1'b1; bus.s_rdata_i = 48'h55;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 4) begin
        bus.m0_req_i = 1'b0;
        bus.m1_req_i = 1'b0;
      end
      neg();
      if ((bus.m0_ready_o || bus.m1_ready_o) && k < 3) begin
        g[k] = grant;
        k++;
      end
    end
    chk("contend_count", k, 3);
`ifdef AMBER48_DMEM_ARB_RR_EN
    ge[0] = 1'b0; ge[1] = 1'b1; ge[2] = 1'b0;
`else
    ge[0] = 1'b0; ge[1] = 1'b0; ge[2] = 1'b0;
`endif
    for (int i = 0; i < 3; i++) chk($sformatf("contend_grant%0d", i), g[i], ge[i]);

    // m0 read, memory ready one cycle after s_req_o
    step();
    idle_inputs();
    bus.m0_req_i = 1'b1; bus.m0_addr_i = 48'h000000000010;
    neg();
    chk("rd_idle_sreq", bus.s_req_o, 1'b0);
    step();
    neg();
    chk("rd_sreq", bus.s_req_o, 1'b1);
    chk("rd_saddr", bus.s_addr_o, 48'h10);
    chk("rd_wait_rdy", bus.m0_ready_o, 1'b0);
    step();
    bus.s_ready_i = 1'b1; bus.s_rdata_i = 48'h123456789ABC;
    neg();
    chk("rd_rdy", bus.m0_ready_o, 1'b1);
    chk("rd_rdata", bus.m0_rdata_o, 48'h123456789ABC);
    chk("rd_trap", bus.m0_trap_o, 1'b0);
    step();
    idle_inputs();
    neg();
    chk("rd_done_rdy", bus.m0_ready_o, 1'b0);
    chk("rd_done_busy", busy, 1'b0);

    // m1 write held stable while requester inputs change (and req drops)
    step();
    bus.m1_req_i = 1'b1; bus.m1_we_i = 1'b1; bus.m1_addr_i = 48'h20; bus.m1_wdata_i = 48'hAAAA;
    step();
    bus.m1_req_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_addr_i = 48'h999; bus.m1_wdata_i = 48'h5555;
    for (int i = 0; i < 2; i++) begin
      neg();
      chk("wr_saddr", bus.s_addr_o, 48'h20);
      chk("wr_swdata", bus.s_wdata_o, 48'hAAAA);
      chk("wr_swe", bus.s_we_o, 1'b1);
      step();
    end
    bus.s_ready_i = 1'b1; bus.s_trap_i = 1'b1; bus.s_rdata_i = 48'h77;
    neg();
    chk("wr_m1_rdy", bus.m1_ready_o, 1'b1);
    chk("wr_m1_trap", bus.m1_trap_o, 1'b1);
    chk("wr_m0_rdy", bus.m0_ready_o, 1'b0);
    chk("wr_grant", grant, 1'b1);
    step();
    idle_inputs();
    neg();
    chk("wr_done_busy", busy, 1'b0);

    // Timeout: memory never ready
    step();
    bus.m0_req_i = 1'b1; bus.m0_addr_i = 48'h30; bus.s_rdata_i = 48'hDEAD;
    for (int b = 1; b <= 4; b++) begin
      step();
      neg();
      if (b < 4) chk("to_wait_rdy", bus.m0_ready_o, 1'b0);
    end
    chk("to_rdy", bus.m0_ready_o, 1'b1);
    chk("to_trap", bus.m0_trap_o, 1'b1);
    chk("to_rdata", bus.m0_rdata_o, 48'h0);
    step();
    bus.m0_req_i = 1'b0;
    neg();
    chk("to_sreq_drop", bus.s_req_o, 1'b0);

    // Ready coincides with the timeout cycle
    step();
    bus.m0_req_i = 1'b1; bus.m0_addr_i = 48'h40;
    for (int b = 1; b <= 3; b++) step();
    step();
    bus.s_ready_i = 1'b1; bus.s_trap_i = 1'b0; bus.s_rdata_i = 48'h0BADC0DE;
    neg();
    chk("tie_rdy", bus.m0_ready_o, 1'b1);
    chk("tie_trap", bus.m0_trap_o, 1'b0);
    chk("tie_rdata", bus.m0_rdata_o, 48'h0BADC0DE);
    step();
    idle_inputs();

    // Reset in the 2nd BUSY cycle
    step();
    bus.m0_req_i = 1'b1; bus.m0_addr_i = 48'h50;
    step();
    step();
    rst_n = 1'b0;
    bus.s_ready_i = 1'b1;
    #1;
    chk("midrst_zero", any_out, 1'b0);
    neg();
    chk("midrst_no_rdy", bus.m0_ready_o, 1'b0);
    step();
    idle_inputs();
    step();
    rst_n = 1'b1;
    bus.m0_req_i = 1'b1; bus.m1_req_i = 1'b1; bus.m1_addr_i = 48'h60;
    neg();
    chk("rel_idle", busy, 1'b0);
    step();
    bus.s_ready_i = 1'b1; bus.s_rdata_i = 48'h42;
    neg();
    chk("rel_grant", grant, 1'b0);
    chk("rel_rdy", bus.m0_ready_o, 1'b1);
    chk("rel_rdata", bus.m0_rdata_o, 48'h42);
    step();
    idle_inputs();
    step();
    neg();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/amber48_dmem_arb.md
AMBER48_DMEM_ARB -- requirements
Module: amber48_dmem_arb

Interface
REQ-001 SHALL take parameter TIMEOUT_CYCLES, default 255, max cycles a granted access may wait for s_ready_i; 0 disables the timeout.
REQ-002 SHALL take XLEN from amber48_pkg (48).
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 m0_req_i / m0_we_i  input  1 / 1  core port request / write enable.
REQ-006 m0_addr_i / m0_wdata_i  input  XLEN / XLEN  core port address / write data.
REQ-007 m0_rdata_o / m0_ready_o / m0_trap_o  output  XLEN / 1 / 1  core port read data / completion / fault.
REQ-008 m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_rdata_o, m1_ready_o, m1_trap_o  same directions and widths as m0; debug/loader port.
REQ-009 s_req_o / s_we_o  output  1 / 1  request / write enable to amber48_dmem.
REQ-010 s_addr_o / s_wdata_o  output  XLEN / XLEN  address / write data to amber48_dmem.
REQ-011 s_rdata_i / s_ready_i / s_trap_i  input  XLEN / 1 / 1  read data / completion / fault from amber48_dmem.
REQ-012 busy_o / grant_o  output  1 / 1  transaction in flight / index of granted port.

Function
REQ-013 SHALL implement FSM with states IDLE and BUSY.
REQ-014 IDLE: with any mX_req_i high, SHALL select a winner, latch its we/addr/wdata and the grant index, and enter BUSY on the next edge.
REQ-015 BUSY: SHALL drive s_req_o=1 and s_we_o/s_addr_o/s_wdata_o from the latched registers, stable regardless of requester inputs.
REQ-016 Latency: request sampled in IDLE at cycle N gives s_req_o=1 in cycle N+1; best-case completion in cycle N+1 with a same-cycle s_ready_i.
REQ-017 BUSY with s_ready_i=1: SHALL assert the granted mX_ready_o for that cycle, pass mX_rdata_o=s_rdata_i and mX_trap_o=s_trap_i, and return to IDLE next edge.
REQ-018 Non-granted port: SHALL hold ready=0, trap=0, rdata=0 in all cycles.
REQ-019 Timeout counter: SHALL clear on entry to BUSY and increment each BUSY cycle without s_ready_i.
REQ-020 Timeout fire: when the counter equals TIMEOUT_CYCLES-1 with s_ready_i=0, SHALL assert granted ready=1, trap=1, rdata=0 and return to IDLE; s_req_o drops next cycle.
REQ-021 Simultaneous s_ready_i and timeout in one cycle: s_ready_i SHALL take precedence; trap=s_trap_i.
REQ-022 Request dropped by the granted port while BUSY: the transaction SHALL still complete downstream; ready is still pulsed.
REQ-023 Requesters drop req the cycle after ready; a req still high in the following IDLE cycle SHALL be arbitrated as a new request.
REQ-024 busy_o SHALL equal (state==BUSY); grant_o SHALL hold the latched index.

Reset
REQ-025 On rst_ni low: state=IDLE, counter=0, latched fields=0, grant=0, round-robin pointer selects m0 next.
REQ-026 All outputs SHALL be 0 during reset; reset mid-transaction SHALL abandon it without a ready pulse.

Configuration
REQ-027 Without AMBER48_DMEM_ARB_RR_EN: fixed priority; m0 SHALL win when both request in IDLE.
REQ-028 With AMBER48_DMEM_ARB_RR_EN: round-robin; when both request, the port not granted last SHALL win; a pointer updates on each grant.

Verification
REQ-029 m0 read addr 0x000000000010, s_ready_i one cycle after s_req_o, rdata 0x123456789ABC -> m0_ready_o pulses once, m0_rdata_o=0x123456789ABC, m0_trap_o=0.
REQ-030 m0 and m1 request in the same cycle, three back-to-back times -> fixed: grants 0,0,0 while m0 holds req; RR build: grants 0,1,0.
REQ-031 m1 write addr 0x20 data 0xAAAA, m1 inputs changed while BUSY -> s_addr_o/s_wdata_o stay 0x20/0xAAAA until ready.
REQ-032 TIMEOUT_CYCLES=4, s_ready_i never high -> m0_ready_o=1 and m0_trap_o=1 in the 4th BUSY cycle; s_req_o=0 next cycle.
REQ-033 TIMEOUT_CYCLES=4, s_ready_i high in the 4th BUSY cycle with s_trap_i=0 -> m0_trap_o=0.
REQ-034 rst_ni low in the 2nd BUSY cycle -> all outputs 0 immediately, no ready pulse; after release the first request is granted normally.
